// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, op codes and FSM states for the EX-stage mul/div unit
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_MUL    = 5'b10000;
    localparam logic [4:0] ALU_MULH   = 5'b10001;
    localparam logic [4:0] ALU_MULHSU = 5'b10010;
    localparam logic [4:0] ALU_MULHU  = 5'b10011;
    localparam logic [4:0] ALU_DIV    = 5'b10100;
    localparam logic [4:0] ALU_DIVU   = 5'b10101;
    localparam logic [4:0] ALU_REM    = 5'b10110;
    localparam logic [4:0] ALU_REMU   = 5'b10111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    function automatic logic is_md_op(input logic [4:0] alu_ctl);
        return alu_ctl[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/exe_muldiv_unit_if.sv
// rtl/exe_muldiv_unit_if.sv - EX-stage request/response bundle of the mul/div unit
interface exe_muldiv_unit_if;
    import muldiv_pkg::*;

    logic [4:0]      ALUControl_E;
    logic [XLEN-1:0] srcA_E;
    logic [XLEN-1:0] srcB_E;
    logic            kill_E;
    logic            stall_md;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output ALUControl_E, srcA_E, srcB_E, kill_E,
        input  stall_md, busy, done, result
    );

    modport slave (
        input  ALUControl_E, srcA_E, srcB_E, kill_E,
        output stall_md, busy, done, result
    );

endinterface

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - operand/accumulator registers, radix-2 mul/div step and sign fix-up
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         issue,
    input  logic         step,
    input  logic         finish,
    input  logic [2:0]   op_in,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         special,
    output logic [W-1:0] result
);

    logic [W-1:0]   a_q, b_q;
    logic [2*W-1:0] acc_q;
    logic [2:0]     op_q;
    logic           sa_q, sb_q;

    logic           a_signed, b_signed, neg_a, neg_b;
    logic           div_zero, div_ovf;
    logic [W-1:0]   special_res;
    logic [W:0]     mul_sum;
    logic [W:0]     div_rem_sh;
    logic [W-1:0]   div_rem_sub;
    logic           div_ge;
    logic [W-1:0]   a_nxt;
    logic [2*W-1:0] acc_nxt;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quot, rem, fin_res;

    assign a_signed = (op_in == 3'b001) || (op_in == 3'b010) || (op_in == 3'b100) || (op_in == 3'b110);
    assign b_signed = (op_in == 3'b001) || (op_in == 3'b100) || (op_in == 3'b110);
    assign neg_a    = a_signed & a_in[W-1];
    assign neg_b    = b_signed & b_in[W-1];

    assign div_zero    = op_in[2] && (b_in == '0);
    assign div_ovf     = op_in[2] && !op_in[0] && (a_in == {1'b1, {(W-1){1'b0}}}) && (&b_in);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (op_in[1] ? a_in : '1)
                                  : (op_in[1] ? '0 : {1'b1, {(W-1){1'b0}}});

    // Multiply: a_q is the shifting multiplier, product builds up in acc_q from the top.
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (a_q[0] ? b_q : '0)};

    // Divide: quotient bits shift into a_q as the dividend shifts out; remainder lives in acc_q low half.
    assign div_rem_sh  = {acc_q[W-1:0], a_q[W-1]};
    assign div_ge      = div_rem_sh >= {1'b0, b_q};
    assign div_rem_sub = div_rem_sh[W-1:0] - b_q;

    always_comb begin
        a_nxt   = a_q;
        acc_nxt = acc_q;
        if (op_q[2]) begin
            a_nxt   = {a_q[W-2:0], div_ge};
            acc_nxt = {{W{1'b0}}, (div_ge ? div_rem_sub : div_rem_sh[W-1:0])};
        end else begin
            a_nxt   = a_q >> 1;
            acc_nxt = {mul_sum, acc_q[W-1:1]};
        end
    end

    always_comb begin
        prod    = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
        quot    = (sa_q ^ sb_q) ? -a_nxt : a_nxt;
        rem     = sa_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
        fin_res = prod[W-1:0];
        if (op_q[2])
            fin_res = op_q[1] ? rem : quot;
        else if (op_q[1:0] != 2'b00)
            fin_res = prod[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            op_q   <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            result <= '0;
        end else if (issue) begin
            a_q   <= neg_a ? -a_in : a_in;
            b_q   <= neg_b ? -b_in : b_in;
            acc_q <= '0;
            op_q  <= op_in;
            sa_q  <= neg_a;
            sb_q  <= neg_b;
            if (special)
                result <= special_res;
        end else if (step) begin
            a_q   <= a_nxt;
            acc_q <= acc_nxt;
            if (finish)
                result <= fin_res;
        end
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// rtl/exe_muldiv_unit.sv - iterative RV32M mul/div unit: issue/busy/done FSM, counter and pipeline stall
module exe_muldiv_unit #(
    parameter int XLEN  = muldiv_pkg::XLEN,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    exe_muldiv_unit_if.slave   md
);
    import muldiv_pkg::*;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             is_md, issue, special, last, step, finish;

    assign is_md  = is_md_op(md.ALUControl_E);
    assign issue  = (state_q == IDLE) && is_md && !md.kill_E;
    assign last   = cnt_q == CNT_W'(XLEN - 1);
    assign step   = (state_q == BUSY) && !md.kill_E;
    assign finish = step && last;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = special ? DONE : BUSY;
            BUSY:    if (md.kill_E) state_d = IDLE;
                     else if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (issue)
                cnt_q <= '0;
            else if (state_q == BUSY)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Low in DONE so the pipeline advances on the completing edge.
    assign md.stall_md = !reset && (issue || (state_q == BUSY));
    assign md.busy     = state_q == BUSY;
    assign md.done     = state_q == DONE;

    muldiv_datapath #(.W(XLEN)) u_datapath (
        .clk     (clk),
        .reset   (reset),
        .issue   (issue),
        .step    (step),
        .finish  (finish),
        .op_in   (md.ALUControl_E[2:0]),
        .a_in    (md.srcA_E),
        .b_in    (md.srcB_E),
        .special (special),
        .result  (md.result)
    );

endmodule

// File: doc/exe_muldiv_unit.md
Name: exe_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage ALU control code and the forwarded operands. Runs MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU over multiple cycles.
- Raises a stall that freezes PC, IF/ID and ID/EX while an operation is in flight. EX muxes `result` into ALU-result when `done`=1.

Parameters:
- XLEN, 32, operand/result width; iteration count = XLEN.
- CNT_W, 5, iteration counter width = log2(XLEN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ALUControl_E  in  5  EX-stage ALU operation code
- srcA_E  in  XLEN  operand A after forwarding mux (rs1)
- srcB_E  in  XLEN  operand B after forwarding mux (rs2)
- kill_E  in  1  abort current/issuing op (EX flush)
- stall_md  out  1  freeze PC, IF/ID, ID/EX; combinational
- busy  out  1  registered; state==BUSY
- done  out  1  registered; high exactly one cycle when result is valid
- result  out  XLEN  registered; holds last completed result

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Decode: is_md = (ALUControl_E[4:3]==2'b10). Low 3 bits select the op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Reset values: state IDLE; busy 0; done 0; result 0; counter 0; internal operand/accumulator regs 0. `stall_md` evaluates to 0 while `reset`=1.
- States: IDLE, BUSY, DONE.
- IDLE, when is_md and not kill_E:
  - Latch operand magnitudes, sign flags and op; clear accumulator; counter=0.
  - Special divide cases skip BUSY: next state DONE with `result` written directly.
  - Otherwise next state BUSY.
- BUSY: one radix-2 step per cycle.
  - Multiply: shift-add on a 2*XLEN product of unsigned magnitudes.
  - Divide: restoring shift-subtract on unsigned magnitudes.
  - Counter increments each cycle.
  - In the cycle with counter==XLEN-1, write the sign-corrected result into `result` and go to DONE.
- DONE: `done`=1 for this single cycle, then IDLE unconditionally. `start` is not re-sampled in DONE, even though ID/EX still holds the same instruction this cycle.
- Stall: stall_md = (IDLE and is_md and not kill_E) or BUSY. It is low in DONE, so the pipeline advances on the DONE edge.
- Latency: issue cycle = cycle 0.
  - Normal op: BUSY cycles 1..32, `done` at cycle 33.
  - Special-case divide: `done` at cycle 1.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL returns product[31:0]; the H variants return product[63:32].
  - Product is negated when the sign flags differ.
  - Quotient is negated when the dividend and divisor signs differ. Remainder takes the dividend's sign.
- Special divide cases:
  - Divisor==0: quotient = all ones; remainder = dividend (A).
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- kill_E:
  - Asserted in IDLE: blocks issue.
  - Asserted in BUSY: return to IDLE next edge; `result` unchanged; `done` not asserted.
  - Asserted in DONE: ignored.
- Reset mid-operation: return to IDLE; all outputs go to their reset values.
- `result` changes only on completion; it holds across IDLE.

Decomposition:
- Package `muldiv_pkg`:
  - ALU op-code localparams: ALU_MUL=5'b10000 … ALU_REMU=5'b10111.
  - State enum: md_state_t {IDLE, BUSY, DONE}.
  - XLEN constant.
- One natural sub-module: `muldiv_datapath`. It owns the operand/accumulator registers, the shift-add/shift-subtract step and the sign correction. The top keeps the FSM, counter and stall logic.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> stall_md high cycles 0–32; done at cycle 33; result 0xFFFFFFEB.
- MULH A=0x80000000, B=0x80000000 -> result 0x40000000.
- MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> result 0xFFFFFFFF. MULHU with the same operands -> result 0xFFFFFFFE.
- DIV A=-7, B=2 -> result 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU A=100, B=7 -> result 14.
- DIVU A=5, B=0 -> done at cycle 1; result 0xFFFFFFFF. REM A=0x80000000, B=0xFFFFFFFF -> done at cycle 1; result 0.
- Start MUL, assert kill_E at cycle 10 -> IDLE at cycle 11; done never asserted; result unchanged. In a second run, assert reset at cycle 20 -> all outputs 0 next cycle. Back-to-back MUL;MUL -> second issues the cycle after DONE.
